// File: rtl/millcore_pkg.sv
// Shared constants, instruction layout and decode helper for the millcore belt machine.
package millcore_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned BELT_DEPTH = 16;
    localparam int unsigned IDX_W      = 4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    localparam int unsigned OP_LSB  = 28;
    localparam int unsigned FN_LSB  = 24;
    localparam int unsigned RA_LSB  = 20;
    localparam int unsigned RB_LSB  = 16;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = 16;

    localparam logic [3:0] OP_DROP    = 4'h0;
    localparam logic [3:0] OP_DROPREL = 4'h1;
    localparam logic [3:0] OP_ALU     = 4'h2;
    localparam logic [3:0] OP_BRANCH  = 4'h4;

    localparam logic [3:0] FN_ADD  = 4'h0;
    localparam logic [3:0] FN_SUB  = 4'h1;
    localparam logic [3:0] FN_OR   = 4'h2;
    localparam logic [3:0] FN_AND  = 4'h3;
    localparam logic [3:0] FN_XOR  = 4'h4;
    localparam logic [3:0] FN_SHL  = 4'h5;
    localparam logic [3:0] FN_SHR  = 4'h6;
    localparam logic [3:0] FN_SLTU = 4'h7;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0]       op;
        logic [3:0]       fn;
        logic [IDX_W-1:0] ra;
        logic [IDX_W-1:0] rb;
        logic [IMM_W-1:0] imm;
    } instr_t;

    function automatic instr_t decode(input logic [XLEN-1:0] w);
        instr_t d;
        d.op  = w[OP_LSB +: 4];
        d.fn  = w[FN_LSB +: 4];
        d.ra  = w[RA_LSB +: IDX_W];
        d.rb  = w[RB_LSB +: IDX_W];
        d.imm = w[IMM_LSB +: IMM_W];
        return d;
    endfunction

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/millcore_alu.sv
// Combinational belt ALU: y_c = f(a, b) selected by fn, modulo 2^32, no flags.
module millcore_alu
    import millcore_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      fn,
    output logic [XLEN-1:0] y_c
);

    always_comb begin
        y_c = '0;
        case (fn)
            FN_ADD:  y_c = a + b;
            FN_SUB:  y_c = a - b;
            FN_OR:   y_c = a | b;
            FN_AND:  y_c = a & b;
            FN_XOR:  y_c = a ^ b;
            FN_SHL:  y_c = a << b[4:0];
            FN_SHR:  y_c = a >> b[4:0];
            FN_SLTU: y_c = XLEN'(a < b);
            default: y_c = '0;
        endcase
    end

endmodule

// File: rtl/soc.sv
// millcore top: fetch/exec FSM, pc, instruction register and 16-entry belt.
module soc
    import millcore_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata
);

    state_e                           state_q, state_d;
    logic                             valid_q, valid_d;
    logic [XLEN-1:0]                  pc_q, pc_d;
    logic [XLEN-1:0]                  ir_q, ir_d;
    logic [BELT_DEPTH-1:0][XLEN-1:0]  belt_q, belt_d;

    instr_t          ins;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_y_c;
    logic            push;
    logic [XLEN-1:0] push_val;

    // Operands always come from the belt as it stood before this instruction.
    always_comb begin
        ins  = decode(ir_q);
        op_a = belt_q[ins.ra];
        op_b = belt_q[ins.rb];
    end

    millcore_alu u_alu (
        .a   (op_a),
        .b   (op_b),
        .fn  (ins.fn),
        .y_c (alu_y_c)
    );

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        belt_d   = belt_q;
        push     = 1'b0;
        push_val = '0;

        case (state_q)
            ST_FETCH: begin
                // valid_q gates ready so a response seen during/just after reset is dropped.
                valid_d = 1'b1;
                if (valid_q && mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = ST_EXEC;
                    valid_d = 1'b0;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
                case (ins.op)
                    OP_DROP: begin
                        push     = 1'b1;
                        push_val = sext_imm(ins.imm);
                    end
                    OP_DROPREL: begin
                        push     = 1'b1;
                        push_val = pc_q + sext_imm(ins.imm);
                    end
                    OP_ALU: begin
                        push     = 1'b1;
                        push_val = alu_y_c;
                    end
                    OP_BRANCH: begin
                        if (op_a != '0) begin
                            pc_d = {op_b[XLEN-1:2], 2'b00};
                        end
                    end
                    default: ;
                endcase
                if (push) begin
                    belt_d = {belt_q[BELT_DEPTH-2:0], push_val};
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            belt_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            belt_q  <= belt_d;
        end
    end

    assign mem_valid = valid_q;
    assign mem_addr  = pc_q;

endmodule

// File: tb/tb_soc.sv
// Self-checking bench for soc: 1-cycle read memory, belt/pc reference model, vectors and random programs.
module tb_soc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [256];
    logic [31:0] m_belt [16];
    logic [31:0] m_pc;

    soc dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Answers one cycle after seeing valid with a single-cycle ready pulse; ignores rst on purpose.
    always @(posedge clk) begin
        mem_ready <= mem_valid && !mem_ready;
        mem_rdata <= imem[mem_addr[9:2]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f_drop(input logic [15:0] imm);
        return {4'h0, 12'h000, imm};
    endfunction
    function automatic logic [31:0] f_alu(input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb);
        return {4'h2, fn, ra, rb, 16'h0000};
    endfunction
    function automatic logic [31:0] f_br(input logic [3:0] ra, input logic [3:0] rb);
        return {4'h4, 4'h0, ra, rb, 16'h0000};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a | b;
            4'd3: return a & b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_push(input logic [31:0] v);
        for (int i = 15; i > 0; i--) m_belt[i] = m_belt[i-1];
        m_belt[0] = v;
    endtask

    task automatic model_exec(input logic [31:0] w);
        logic [3:0]  op;
        logic [31:0] imm32;
        logic [31:0] a;
        logic [31:0] b;
        op    = w[31:28];
        imm32 = {{16{w[15]}}, w[15:0]};
        a     = m_belt[w[23:20]];
        b     = m_belt[w[19:16]];
        case (op)
            4'd0: begin m_push(imm32);               m_pc = m_pc + 4; end
            4'd1: begin m_push(m_pc + imm32);        m_pc = m_pc + 4; end
            4'd2: begin m_push(ref_alu(w[27:24], a, b)); m_pc = m_pc + 4; end
            4'd4: m_pc = (a != 0) ? (b & 32'hFFFF_FFFC) : m_pc + 4;
            default: m_pc = m_pc + 4;
        endcase
    endtask

    task automatic load(input logic [31:0] prog []);
        for (int i = 0; i < 256; i++) imem[i] = 32'h3000_0000;
        foreach (prog[i]) imem[i] = prog[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", 32'(mem_valid), 32'd0);
        end
        chk("rst_addr", mem_addr, 32'h0);
        rst  = 1'b0;
        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) m_belt[i] = 32'h0;
        @(negedge clk);
        chk("first_valid", 32'(mem_valid), 32'd1);
        chk("first_addr", mem_addr, 32'h0);
    endtask

    // Precondition: mem_valid=1 at the current negedge. Executes one instruction.
    task automatic step(input string tag);
        int gap;
        bit went_low;
        bit seen;
        int bad;
        chk({tag, "_addr"}, mem_addr, m_pc);
        model_exec(imem[m_pc[9:2]]);
        gap = 0; went_low = 0; seen = 0;
        while (!seen && gap < 12) begin
            @(negedge clk);
            gap++;
            if (!mem_valid) went_low = 1;
            else if (went_low) seen = 1;
        end
        chk({tag, "_gap"}, 32'(gap), 32'd3);
        bad = -1;
        for (int i = 0; i < 16; i++)
            if (bad < 0 && dut.belt_q[i] !== m_belt[i]) bad = i;
        if (bad < 0) chk({tag, "_belt"}, dut.belt_q[0], m_belt[0]);
        else chk($sformatf("%s_belt%0d", tag, bad), dut.belt_q[bad], m_belt[bad]);
    endtask

    typedef struct {
        logic [15:0] a_imm;
        logic [15:0] b_imm;
        logic [3:0]  fn;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t tbl [12];
    logic [31:0] exp_addr [8];

    initial begin
        logic [31:0] prog [];

        tbl[0]  = '{16'd5,    16'd3,    4'd1, 4'd1, 4'd0, 32'd2};
        tbl[1]  = '{16'd3,    16'd2,    4'd7, 4'd0, 4'd1, 32'd1};
        tbl[2]  = '{16'hFFFF, 16'd1,    4'd0, 4'd1, 4'd0, 32'd0};
        tbl[3]  = '{16'h00F0, 16'h0F0F, 4'd2, 4'd1, 4'd0, 32'h0000_0FFF};
        tbl[4]  = '{16'h00FF, 16'h0F0F, 4'd3, 4'd1, 4'd0, 32'h0000_000F};
        tbl[5]  = '{16'h00FF, 16'h0F0F, 4'd4, 4'd1, 4'd0, 32'h0000_0FF0};
        tbl[6]  = '{16'd1,    16'd31,   4'd5, 4'd1, 4'd0, 32'h8000_0000};
        tbl[7]  = '{16'h8000, 16'd4,    4'd6, 4'd1, 4'd0, 32'h0FFF_F800};
        tbl[8]  = '{16'd1,    16'd33,   4'd5, 4'd1, 4'd0, 32'd2};
        tbl[9]  = '{16'd7,    16'd7,    4'd9, 4'd1, 4'd0, 32'd0};
        tbl[10] = '{16'd3,    16'd2,    4'd7, 4'd1, 4'd0, 32'd0};
        tbl[11] = '{16'd0,    16'd1,    4'd1, 4'd1, 4'd0, 32'hFFFF_FFFF};

        // Reference program: fetch stream, belt before branch, second pass of address 8.
        prog = '{32'h0000_0001, 32'h1000_0004, 32'h0000_0001, 32'h2002_0000,
                 32'h2222_0000, 32'h2244_0000, 32'h4011_0000};
        exp_addr = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd8};
        load(prog);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("prog_fetch%0d", i), mem_addr, exp_addr[i]);
            if (i == 6) begin
                chk("prebr_b0", dut.belt_q[0], 32'd1);
                chk("prebr_b1", dut.belt_q[1], 32'd8);
                chk("prebr_b2", dut.belt_q[2], 32'd2);
                chk("prebr_b3", dut.belt_q[3], 32'd1);
                chk("prebr_b4", dut.belt_q[4], 32'd8);
                chk("prebr_b5", dut.belt_q[5], 32'd1);
            end
            step("prog");
        end
        chk("pass2_b0", dut.belt_q[0], 32'd1);
        chk("pass2_b1", dut.belt_q[1], 32'd1);

        // ALU vectors: drop a; drop b; alu fn ra rb.
        for (int t = 0; t < 12; t++) begin
            prog = '{f_drop(tbl[t].a_imm), f_drop(tbl[t].b_imm), f_alu(tbl[t].fn, tbl[t].ra, tbl[t].rb)};
            load(prog);
            do_reset();
            for (int k = 0; k < 3; k++) step("alu");
            chk($sformatf("alu_vec%0d", t), dut.belt_q[0], tbl[t].exp);
        end

        // Branch not taken.
        prog = '{f_drop(16'd0), f_br(4'd0, 4'd0)};
        load(prog);
        do_reset();
        step("nt"); step("nt");
        chk("nt_addr", mem_addr, 32'd8);

        // Branch to its own address.
        prog = '{f_drop(16'd8), f_drop(16'd1), f_br(4'd0, 4'd1)};
        load(prog);
        do_reset();
        for (int k = 0; k < 3; k++) step("self");
        chk("self_addr1", mem_addr, 32'd8);
        step("self");
        chk("self_addr2", mem_addr, 32'd8);

        // pc wrap from 0xFFFFFFFC to 0.
        prog = '{f_drop(16'hFFFC), f_drop(16'd1), f_br(4'd0, 4'd1)};
        load(prog);
        imem[255] = f_drop(16'h0055);
        do_reset();
        for (int k = 0; k < 3; k++) step("wrap");
        chk("wrap_hi", mem_addr, 32'hFFFF_FFFC);
        step("wrap");
        chk("wrap_lo", mem_addr, 32'h0);
        chk("wrap_b0", dut.belt_q[0], 32'h55);

        // Undefined opcode leaves the belt alone.
        prog = '{f_drop(16'd7), 32'h3123_4567};
        load(prog);
        do_reset();
        step("undef"); step("undef");
        chk("undef_b0", dut.belt_q[0], 32'd7);
        chk("undef_b1", dut.belt_q[1], 32'd0);
        chk("undef_addr", mem_addr, 32'd8);

        // Random programs, enough pushes to overflow the belt and hit index 15.
        for (int i = 0; i < 256; i++) begin
            int r;
            logic [3:0] op;
            r = $urandom_range(0, 9);
            op = (r < 3) ? 4'h0 : (r == 3) ? 4'h1 : (r < 7) ? 4'h2 : (r == 7) ? 4'h4 : (r == 8) ? 4'h3 : 4'hF;
            imem[i] = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 16'($urandom)};
        end
        do_reset();
        for (int k = 0; k < 300; k++) step("rnd");

        // Reset mid-fetch: rst lands while valid is high and a response is in flight.
        chk("midrst_valid_pre", 32'(mem_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 16; i++)
            chk($sformatf("midrst_belt%0d", i), dut.belt_q[i], 32'd0);
        step("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
